// File: rtl/spi_master_tx.sv
// SPI master: one MSB-first, full-duplex byte per start request, SLK half-period of DIV clocks.
// Define SPI_MASTER_LOOPBACK_EN to feed the rx shift register from the MOSI register instead of MISO.
module spi_master_tx #(
  parameter int unsigned DIV   = 2,
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] tx_data,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] rx_data,
  output logic             SLK,
  output logic             CS,
  output logic             MOSI,
  input  logic             MISO
);

  typedef enum logic [2:0] {StIdle, StSetup, StHigh, StLow, StHold} state_e;

  state_e           state_q, state_d;
  logic [7:0]       cnt_q, cnt_d;
  logic [2:0]       bit_q, bit_d;
  logic [WIDTH-1:0] tx_q, tx_d, rx_q, rx_d, rx_data_q, rx_data_d;
  logic             slk_q, slk_d, cs_q, cs_d, mosi_q, mosi_d;
  logic             done_q, done_d, busy_q, busy_d;
  logic             tc, rx_in;

  assign tc = (cnt_q == 8'(DIV - 1));

`ifdef SPI_MASTER_LOOPBACK_EN
  logic unused_miso;
  assign unused_miso = MISO;
  assign rx_in       = mosi_q;
`else
  assign rx_in = MISO;
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = (state_q == StIdle || tc) ? 8'd0 : cnt_q + 8'd1;
    bit_d     = bit_q;
    tx_d      = tx_q;
    rx_d      = rx_q;
    rx_data_d = rx_data_q;
    slk_d     = slk_q;
    cs_d      = cs_q;
    mosi_d    = mosi_q;
    done_d    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          tx_d    = tx_data;
          cs_d    = 1'b1;
          mosi_d  = tx_data[WIDTH-1];
          bit_d   = 3'd0;
          state_d = StSetup;
        end
      end
      StSetup: begin
        if (tc) begin
          slk_d   = 1'b1;
          state_d = StHigh;
        end
      end
      StHigh: begin
        if (tc) begin
          slk_d = 1'b0;
          rx_d  = {rx_q[WIDTH-2:0], rx_in};
          if (bit_q == 3'(WIDTH - 1)) begin
            state_d = StHold;
          end else begin
            // Next bit goes out on the falling edge, a full phase before the next rise.
            tx_d    = tx_q << 1;
            mosi_d  = tx_q[WIDTH-2];
            bit_d   = bit_q + 3'd1;
            state_d = StLow;
          end
        end
      end
      StLow: begin
        if (tc) begin
          slk_d   = 1'b1;
          state_d = StHigh;
        end
      end
      StHold: begin
        if (tc) begin
          cs_d      = 1'b0;
          mosi_d    = 1'b0;
          rx_data_d = rx_q;
          done_d    = 1'b1;
          state_d   = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      cnt_q     <= 8'd0;
      bit_q     <= 3'd0;
      tx_q      <= '0;
      rx_q      <= '0;
      rx_data_q <= '0;
      slk_q     <= 1'b0;
      cs_q      <= 1'b0;
      mosi_q    <= 1'b0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      tx_q      <= tx_d;
      rx_q      <= rx_d;
      rx_data_q <= rx_data_d;
      slk_q     <= slk_d;
      cs_q      <= cs_d;
      mosi_q    <= mosi_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
    end
  end

  assign SLK     = slk_q;
  assign CS      = cs_q;
  assign MOSI    = mosi_q;
  assign done    = done_q;
  assign busy    = busy_q;
  assign rx_data = rx_data_q;

endmodule

// File: doc/spi_master_tx.md
# spi_master_tx

SPI master for the FPGA SPI lab: generates `SLK`, `CS` and `MOSI` to drive the existing 8-bit SPI slave and captures its `MISO` reply. It sits between the board-side controller logic, which issues one-byte transfer requests, and the off-block SPI pins. One request produces one full 8-bit, MSB-first, full-duplex transfer with a programmable serial clock rate.

## Interface
Parameters:
- `DIV`, 2: system-clock cycles per `SLK` half-period. Legal range is 1 to 255.
- `WIDTH`, 8: bits per transfer. Fixed at 8; no other value is supported.

Ports:
- `clk`  in  1: system clock. All logic is clocked on its rising edge.
- `rst_n`  in  1: reset, asynchronous, active-low.
- `start`  in  1: transfer request. Sampled only while `busy`=0.
- `tx_data`  in  8: byte to send. Latched on the cycle `start` is accepted.
- `busy`  out  1: high while a transfer is in progress.
- `done`  out  1: one-cycle pulse when a transfer completes.
- `rx_data`  out  8: last received byte. Updated together with `done` and held until the next `done`.
- `SLK`  out  1: serial clock. Idles low.
- `CS`  out  1: slave select, active-high. The slave gates `MISO` with it.
- `MOSI`  out  1: serial data out, MSB first.
- `MISO`  in  1: serial data in.

## Operation
- States: IDLE, SETUP, HIGH, LOW, HOLD. A divider counter runs 0..DIV-1 in every non-IDLE state. Its terminal count (TC) marks the end of a phase. A 3-bit bit counter tracks position in the byte.
- IDLE: `start`=1 accepts a request. On acceptance:
  - `tx_data` is loaded into the tx shift register.
  - `CS`<=1, `MOSI`<=tx_data[7], `SLK` stays 0.
  - Bit counter <=0, next state SETUP.
- SETUP, on TC: `SLK`<=1 (first rising edge; the slave samples MOSI), next state HIGH.
- HIGH, on TC:
  - `SLK`<=0.
  - rx shift <= {rx[6:0], MISO}.
  - If the bit counter is 7, next state HOLD.
  - Otherwise the tx register shifts left, `MOSI`<=next bit, the bit counter increments, and next state is LOW.
- LOW, on TC: `SLK`<=1, next state HIGH.
- HOLD, on TC:
  - `CS`<=0, `MOSI`<=0.
  - `rx_data`<=rx shift, `done`<=1 for one cycle.
  - Next state IDLE.
- `busy` is 1 exactly when the state is not IDLE. It is registered and falls in the same cycle `done` rises.
- `start` is ignored while `busy`=1. A change on `tx_data` during a transfer has no effect.
- If `start` is held high continuously, the next transfer is accepted on the first IDLE cycle. `CS` is then low for exactly one `clk` cycle between bytes.
- When `rst_n` is asserted mid-transfer, all state and outputs return to reset values immediately, with no partial `done`. The slave sees a truncated frame.

## Timing
- Reset values: `SLK`=0, `CS`=0, `MOSI`=0, `busy`=0, `done`=0, `rx_data`=8'h00. State is IDLE and all counters are 0.
- From the `start` acceptance edge to the `done` pulse: 17*DIV cycles. This breaks down as 1 SETUP + 8 HIGH + 7 LOW + 1 HOLD phase, each DIV cycles long.
- `MOSI` changes only when `SLK` falls (or at acceptance) and is stable for DIV cycles before each `SLK` rise.
- `MISO` is sampled in the cycle `SLK` falls, DIV cycles after the slave updated it on the rise.
- With DIV=1, `SLK` toggles every `clk` cycle; behaviour is otherwise unchanged.

## Configuration
- `SPI_MASTER_LOOPBACK_EN`:
  - Defined: the rx shift register samples the internal `MOSI` register instead of the `MISO` pin, and `MISO` is ignored. Each completed transfer returns `rx_data`==`tx_data`. All pin outputs behave identically.
  - Undefined: `MISO` is sampled as described in Operation.

## Test plan
- Reset value check: assert `rst_n`=0 → `SLK`=0, `CS`=0, `MOSI`=0, `busy`=0, `done`=0, `rx_data`=0x00. Release reset with `start`=0 → the block stays idle for 50 cycles.
- Single transfer: DIV=2, a bench slave model returns 0x3C MSB-first on `SLK` rising edges, `start` pulse with `tx_data`=0xA5.
  - `MOSI` at the 8 `SLK` rises reads 1,0,1,0,0,1,0,1.
  - Exactly 8 `SLK` rises occur.
  - `done` pulses 34 cycles after acceptance, with `rx_data`=0x3C.
  - `CS` falls in the same cycle `done` rises.
- Busy lockout: during the transfer above, pulse `start` with `tx_data`=0xFF at cycle 10 → no effect on `MOSI`; exactly one `done`.
- Back-to-back: hold `start`=1 with 0x81 then 0x7E → two frames; `CS` is low for exactly 1 cycle between them; 2 `done` pulses 35 cycles apart.
- Reset mid-operation: assert `rst_n`=0 after the 4th `SLK` rise → all outputs at reset values within the same cycle, no `done`. The next transfer after release is correct.
- Loopback (`SPI_MASTER_LOOPBACK_EN` defined, `MISO` tied to 0): `tx_data`=0x5A → `rx_data`=0x5A at `done`.
